demux_route_scheduler: RTL

DEMUX_ROUTE_SCHEDULER -- requirements
Module: demux_route_scheduler

---
 rtl/demux_route_scheduler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/demux_route_scheduler.sv
// Round-robin burst scheduler that routes a 1-bit source stream to one of eight destinations.
// Optional stalled-grant watchdog is enabled by defining DEMUX_SCHED_TIMEOUT_EN.
module demux_route_scheduler #(
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] dst_ready,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       in_ready,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic [7:0] y,
  output logic [7:0] y_valid,
  output logic       busy,
  output logic       burst_done,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] last_sel;
  logic [2:0] winner;
  logic [3:0] beat_cnt;
  logic [4:0] beat_cnt_inc;
  logic [7:0] y_next;
  logic [7:0] y_valid_next;
  logic       accept;
  logic       last_beat;
  logic       load_grant;
  logic       release_grant;
  logic       stall_expire;

  if (BURST_LEN < 1 || BURST_LEN > 16 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("demux_route_scheduler: BURST_LEN or TIMEOUT out of range");
  end

  assign in_ready     = (state == XFER) & dst_ready[sel] & req[sel];
  assign accept       = in_valid & in_ready;
  assign busy         = (state == XFER);
  assign beat_cnt_inc = {1'b0, beat_cnt} + 5'd1;
  assign last_beat    = (beat_cnt_inc == 5'(BURST_LEN));

  // Scan downward so the nearest requester after last_sel is written last and wins.
  always_comb begin
    winner = last_sel;
    for (int i = 8; i >= 1; i--) begin
      if (req[last_sel + 3'(i)]) begin
        winner = last_sel + 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    load_grant    = 1'b0;
    release_grant = 1'b0;
    case (state)
      IDLE: begin
        if (req != 8'd0) begin
          next_state = XFER;
          load_grant = 1'b1;
        end
      end
      XFER: begin
        if (!req[sel] || stall_expire || (accept && last_beat)) begin
          next_state    = IDLE;
          release_grant = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    y_next       = 8'd0;
    y_valid_next = 8'd0;
    if (accept) begin
      y_next[sel]       = in_data;
      y_valid_next[sel] = 1'b1;
    end
  end

  // Releasing always drops the grant, so the following cycle is an IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= 3'd0;
      grant      <= 8'd0;
      last_sel   <= 3'd7;
      beat_cnt   <= 4'd0;
      y          <= 8'd0;
      y_valid    <= 8'd0;
      burst_done <= 1'b0;
    end else begin
      y          <= y_next;
      y_valid    <= y_valid_next;
      burst_done <= release_grant;
      if (load_grant) begin
        sel      <= winner;
        grant    <= 8'd1 << winner;
        beat_cnt <= 4'd0;
      end else if (release_grant) begin
        grant    <= 8'd0;
        last_sel <= sel;
        beat_cnt <= 4'd0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

`ifdef DEMUX_SCHED_TIMEOUT_EN
  logic [7:0] stall_cnt;
  logic       stall;
  logic       timeout_q;

  assign stall        = (state == XFER) & in_valid & req[sel] & ~dst_ready[sel];
  assign stall_expire = stall & (({1'b0, stall_cnt} + 9'd1) >= 9'(TIMEOUT));

  // Only an unbroken run of stalled cycles counts toward revocation.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= stall_expire;
      if (stall && !stall_expire) begin
        stall_cnt <= stall_cnt + 8'd1;
      end else begin
        stall_cnt <= 8'd0;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign stall_expire = 1'b0;
  assign timeout      = 1'b0;
`endif

endmodule
